// File: rtl/rr_req_agent.sv
// Requester-side agent for the round-robin arbiter: queues client requests as counters and tracks wait statistics.
// Optional starvation flags are built only when RR_REQ_AGENT_STARVE_CHECK_EN is defined.
module rr_req_agent #(
   parameter int REQCNT     = 4,
   parameter int MAXPEND    = 3,
   parameter int WAITW      = 16,
   parameter int STARVE_LIM = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [REQCNT-1:0]         cl_req_i,
   output logic [REQCNT-1:0]         cl_full_o,
   output logic [REQCNT-1:0]         cl_gnt_o,
   output logic [REQCNT-1:0]         req_o,
   input  logic [$clog2(REQCNT)-1:0] gnt_num_i,
   input  logic                      gnt_val_i,
   output logic [REQCNT-1:0]         drop_o,
   output logic                      spurious_o,
   input  logic                      stat_clr_i,
   output logic [WAITW-1:0]          max_wait_o,
   output logic [REQCNT-1:0]         starve_o
);

   localparam int CW = $clog2(MAXPEND + 1);
   localparam int IW = $clog2(REQCNT);
   localparam logic [CW-1:0]    FULL_CNT = CW'(MAXPEND);
   localparam logic [WAITW-1:0] WAIT_MAX = '1;

   if (REQCNT < 2 || MAXPEND < 1 ||
       longint'(STARVE_LIM) >= (longint'(1) << WAITW)) begin : g_bad_cfg
      $error("rr_req_agent: illegal parameter combination");
   end

   logic [CW-1:0]    cnt_q  [REQCNT];
   logic [CW-1:0]    cnt_d  [REQCNT];
   logic [WAITW-1:0] wait_q [REQCNT];
   logic [WAITW-1:0] wait_d [REQCNT];
   logic [REQCNT-1:0] hit;
   logic [REQCNT-1:0] gnt_q, gnt_d;
   logic [REQCNT-1:0] drop_q, drop_d;
   logic              spur_q, spur_d;
   logic [WAITW-1:0]  maxw_q, maxw_d;

   // A grant only counts when it names an existing client that has something pending.
   always_comb begin
      hit = '0;
      for (int i = 0; i < REQCNT; i++) begin
         hit[i] = gnt_val_i && (gnt_num_i == IW'(i)) && (cnt_q[i] != '0);
      end
   end

   always_comb begin
      gnt_d  = hit;
      drop_d = stat_clr_i ? '0 : drop_q;
      spur_d = stat_clr_i ? 1'b0 : (spur_q | (gnt_val_i && (hit == '0)));
      for (int i = 0; i < REQCNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cl_req_i[i] && !hit[i]) begin
            if (cnt_q[i] == FULL_CNT) begin
               if (!stat_clr_i) drop_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end else if (!cl_req_i[i] && hit[i]) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
         end
      end
   end

   always_comb begin
      maxw_d = maxw_q;
      for (int i = 0; i < REQCNT; i++) begin
         if (cnt_q[i] == '0 || hit[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != WAIT_MAX) begin
            wait_d[i] = wait_q[i] + WAITW'(1);
         end else begin
            wait_d[i] = wait_q[i];
         end
         if (wait_q[i] > maxw_d) maxw_d = wait_q[i];
      end
      if (stat_clr_i) maxw_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < REQCNT; i++) begin
            cnt_q[i]  <= '0;
            wait_q[i] <= '0;
         end
         gnt_q  <= '0;
         drop_q <= '0;
         spur_q <= 1'b0;
         maxw_q <= '0;
      end else begin
         for (int i = 0; i < REQCNT; i++) begin
            cnt_q[i]  <= cnt_d[i];
            wait_q[i] <= wait_d[i];
         end
         gnt_q  <= gnt_d;
         drop_q <= drop_d;
         spur_q <= spur_d;
         maxw_q <= maxw_d;
      end
   end

`ifdef RR_REQ_AGENT_STARVE_CHECK_EN
   logic [REQCNT-1:0] starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      for (int i = 0; i < REQCNT; i++) begin
         if (wait_q[i] == WAITW'(STARVE_LIM)) starve_d[i] = 1'b1;
      end
      if (stat_clr_i) starve_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) starve_q <= '0;
      else          starve_q <= starve_d;
   end

   assign starve_o = starve_q;
`else
   assign starve_o = '0;
`endif

   // Request view is decoded from registered counts only, so it has no input-to-output path.
   always_comb begin
      for (int i = 0; i < REQCNT; i++) begin
         req_o[i]     = (cnt_q[i] != '0);
         cl_full_o[i] = (cnt_q[i] == FULL_CNT);
      end
   end

   assign cl_gnt_o   = gnt_q;
   assign drop_o     = drop_q;
   assign spurious_o = spur_q;
   assign max_wait_o = maxw_q;

endmodule

// File: tb/tb_rr_req_agent.sv
// Bench for rr_req_agent: directed vector table, randomized run against an integer reference model, reset corners.
module tb_rr_req_agent;

   localparam int REQCNT     = 4;
   localparam int MAXPEND    = 3;
   localparam int WAITW      = 16;
   localparam int STARVE_LIM = 64;
   localparam int WMAX       = (1 << WAITW) - 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cl_req;
   logic [3:0]  cl_full, cl_gnt, req_v, drop_v, starve_v;
   logic [1:0]  gnt_num;
   logic        gnt_val;
   logic        spur_v;
   logic        stat_clr;
   logic [15:0] max_wait;

   int checks = 0;
   int errors = 0;

   // reference model state
   int       pend [4];
   int       wt   [4];
   int       maxw;
   bit [3:0] m_gnt, m_drop, m_starve;
   bit       m_spur;
   int       rr_ptr;

   typedef struct packed {
      logic [3:0] rq;
      logic       gv;
      logic [1:0] gn;
      logic       clr;
      logic [3:0] e_req;
      logic [3:0] e_full;
      logic [3:0] e_gnt;
      logic [3:0] e_drop;
      logic       e_spur;
   } vec_t;

   vec_t tv [25];

   always #5 clk = ~clk;

   rr_req_agent #(.REQCNT(REQCNT), .MAXPEND(MAXPEND), .WAITW(WAITW), .STARVE_LIM(STARVE_LIM)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .cl_req_i(cl_req), .cl_full_o(cl_full), .cl_gnt_o(cl_gnt),
      .req_o(req_v), .gnt_num_i(gnt_num), .gnt_val_i(gnt_val), .drop_o(drop_v),
      .spurious_o(spur_v), .stat_clr_i(stat_clr), .max_wait_o(max_wait), .starve_o(starve_v)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void model_edge();
      int  oldw [4];
      bit  ok;
      bit  served;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin pend[i] = 0; wt[i] = 0; end
         maxw = 0; m_gnt = '0; m_drop = '0; m_spur = 0; m_starve = '0;
         return;
      end
      ok = gnt_val && (int'(gnt_num) < REQCNT) && (pend[gnt_num] > 0);
      oldw = wt;
      m_gnt = '0;
      if (stat_clr) begin m_drop = '0; m_spur = 0; m_starve = '0; end
      else if (gnt_val && !ok) m_spur = 1;
      for (int i = 0; i < 4; i++) begin
         served = ok && (int'(gnt_num) == i);
         if (pend[i] == 0 || served) wt[i] = 0;
         else wt[i] = (oldw[i] < WMAX) ? oldw[i] + 1 : WMAX;
         if (served) m_gnt[i] = 1;
         if (cl_req[i]) begin
            if (!served) begin
               if (pend[i] < MAXPEND) pend[i]++;
               else if (!stat_clr) m_drop[i] = 1;
            end
         end else if (served) begin
            pend[i]--;
         end
`ifdef RR_REQ_AGENT_STARVE_CHECK_EN
         if (!stat_clr && oldw[i] == STARVE_LIM) m_starve[i] = 1;
`endif
      end
      if (stat_clr) maxw = 0;
      else for (int i = 0; i < 4; i++) if (oldw[i] > maxw) maxw = oldw[i];
   endfunction

   task automatic step(input logic [3:0] rq, input logic gv, input logic [1:0] gn, input logic clr);
      cl_req = rq; gnt_val = gv; gnt_num = gn; stat_clr = clr;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic cmp_model(input string tag);
      logic [3:0] e_req, e_full;
      for (int i = 0; i < 4; i++) begin
         e_req[i]  = (pend[i] > 0);
         e_full[i] = (pend[i] == MAXPEND);
      end
      chk({tag, ".req_o"}, 32'(req_v), 32'(e_req));
      chk({tag, ".cl_full_o"}, 32'(cl_full), 32'(e_full));
      chk({tag, ".cl_gnt_o"}, 32'(cl_gnt), 32'(m_gnt));
      chk({tag, ".drop_o"}, 32'(drop_v), 32'(m_drop));
      chk({tag, ".spurious_o"}, 32'(spur_v), 32'(m_spur));
      chk({tag, ".max_wait_o"}, 32'(max_wait), 32'(maxw));
      chk({tag, ".starve_o"}, 32'(starve_v), 32'(m_starve));
   endtask

   // next pending client after the last served one, from the model's view of the counts
   function automatic int rr_pick();
      int c;
      for (int k = 1; k <= 4; k++) begin
         c = (rr_ptr + k) % 4;
         if (pend[c] > 0) return c;
      end
      return -1;
   endfunction

   initial begin
      int pick;
      logic [3:0] rq;
      // rq gv gn clr | req full gnt drop spur
      tv[0]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[1]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0};
      tv[2]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0};
      tv[3]  = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0};
      tv[4]  = '{4'b0010, 1'b0, 2'd0, 1'b0, 4'b0110, 4'b0100, 4'b0000, 4'b0100, 1'b0};
      tv[5]  = '{4'b0010, 1'b0, 2'd0, 1'b0, 4'b0110, 4'b0100, 4'b0000, 4'b0100, 1'b0};
      tv[6]  = '{4'b0000, 1'b1, 2'd1, 1'b0, 4'b0110, 4'b0100, 4'b0010, 4'b0100, 1'b0};
      tv[7]  = '{4'b0000, 1'b1, 2'd1, 1'b0, 4'b0100, 4'b0100, 4'b0010, 4'b0100, 1'b0};
      tv[8]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0};
      tv[9]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0};
      tv[10] = '{4'b0001, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0};
      tv[11] = '{4'b0001, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0};
      tv[12] = '{4'b0001, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tv[13] = '{4'b0001, 1'b1, 2'd0, 1'b0, 4'b0101, 4'b0101, 4'b0001, 4'b0000, 1'b0};
      tv[14] = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tv[15] = '{4'b0000, 1'b1, 2'd3, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b1};
      tv[16] = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b1};
      tv[17] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tv[18] = '{4'b0000, 1'b1, 2'd3, 1'b1, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
      tv[19] = '{4'b0000, 1'b1, 2'd2, 1'b0, 4'b0101, 4'b0001, 4'b0100, 4'b0000, 1'b0};
      tv[20] = '{4'b0000, 1'b1, 2'd2, 1'b0, 4'b0101, 4'b0001, 4'b0100, 4'b0000, 1'b0};
      tv[21] = '{4'b0000, 1'b1, 2'd2, 1'b0, 4'b0001, 4'b0001, 4'b0100, 4'b0000, 1'b0};
      tv[22] = '{4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0};
      tv[23] = '{4'b0000, 1'b1, 2'd0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0};
      tv[24] = '{4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0};

      rr_ptr = 3;
      rst_n = 1'b0;
      step(4'b1111, 1'b0, 2'd0, 1'b0);
      step(4'b1111, 1'b0, 2'd0, 1'b0);
      rst_n = 1'b1;
      cl_req = '0;
      chk("reset.req_o", 32'(req_v), 32'h0);
      chk("reset.cl_full_o", 32'(cl_full), 32'h0);
      chk("reset.cl_gnt_o", 32'(cl_gnt), 32'h0);
      chk("reset.max_wait_o", 32'(max_wait), 32'h0);
      chk("reset.drop_spur", 32'({drop_v, spur_v}), 32'h0);
      chk("reset.starve_o", 32'(starve_v), 32'h0);

      for (int r = 0; r < 25; r++) begin
         step(tv[r].rq, tv[r].gv, tv[r].gn, tv[r].clr);
         chk($sformatf("vec%0d.req_o", r), 32'(req_v), 32'(tv[r].e_req));
         chk($sformatf("vec%0d.cl_full_o", r), 32'(cl_full), 32'(tv[r].e_full));
         chk($sformatf("vec%0d.cl_gnt_o", r), 32'(cl_gnt), 32'(tv[r].e_gnt));
         chk($sformatf("vec%0d.drop_o", r), 32'(drop_v), 32'(tv[r].e_drop));
         chk($sformatf("vec%0d.spurious_o", r), 32'(spur_v), 32'(tv[r].e_spur));
         chk($sformatf("vec%0d.max_wait_o", r), 32'(max_wait), 32'(maxw));
      end

      // round-robin service of random traffic: waits stay bounded
      step(4'b0000, 1'b0, 2'd0, 1'b1);
      cmp_model("clr");
      for (int n = 0; n < 10000; n++) begin
         rq = 4'($urandom_range(0, 15));
         pick = rr_pick();
         if (pick >= 0) begin
            rr_ptr = pick;
            step(rq, 1'b1, 2'(pick), 1'b0);
         end else begin
            step(rq, 1'b0, 2'd0, 1'b0);
         end
         cmp_model("rr");
      end
      chk("rr.max_wait_bound", 32'(max_wait <= 16'd9), 32'd1);

      // unconstrained grants, spurious indices and occasional clears
      for (int n = 0; n < 2000; n++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 63) == 0));
         cmp_model("rand");
      end

      // reset in the middle of traffic while a valid grant is presented
      step(4'b1111, 1'b0, 2'd0, 1'b0);
      step(4'b1111, 1'b0, 2'd0, 1'b0);
      cmp_model("pre_rst");
      rst_n = 1'b0;
      step(4'b0000, 1'b1, 2'd0, 1'b0);
      chk("midrst.cl_gnt_o", 32'(cl_gnt), 32'h0);
      chk("midrst.req_o", 32'(req_v), 32'h0);
      chk("midrst.max_wait_o", 32'(max_wait), 32'h0);
      rst_n = 1'b1;
      step(4'b0000, 1'b1, 2'd1, 1'b0);
      chk("postrst.cl_gnt_o", 32'(cl_gnt), 32'h0);
      chk("postrst.spurious_o", 32'(spur_v), 32'h1);
      cmp_model("postrst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_req_agent.md
Name: rr_req_agent

Overview:
- Requester-side agent for the round-robin arbiter (rr_top): the opposite end of its req/grant interface.
- Accepts single-cycle request pulses from REQCNT clients and queues up to MAXPEND outstanding requests per client as counters.
- Drives the arbiter's request vector, consumes its grant index/valid, returns a one-hot grant pulse to the served client, and keeps wait-time statistics in hardware.

Parameters:
- REQCNT, 4, number of clients; must be >= 2.
- MAXPEND, 3, maximum outstanding requests per client; must be >= 1.
- WAITW, 16, width of wait-time counters and of max_wait_o.
- STARVE_LIM, 64, wait threshold in cycles for the optional starvation check; must be < 2**WAITW.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- cl_req_i  in  REQCNT  per-client request pulse; each high cycle adds one request.
- cl_full_o  out  REQCNT  client pending count == MAXPEND.
- cl_gnt_o  out  REQCNT  one-hot pulse; one request of that client was served.
- req_o  out  REQCNT  to arbiter req_i; bit i = (pending count i != 0).
- gnt_num_i  in  $clog2(REQCNT)  arbiter grant index (req_num_o).
- gnt_val_i  in  1  arbiter grant valid (req_num_val_o).
- drop_o  out  REQCNT  sticky; a request arrived while that client was full.
- spurious_o  out  1  sticky; valid grant to a client with count 0, or index >= REQCNT.
- stat_clr_i  in  1  clears max_wait_o, drop_o, spurious_o and starve_o.
- max_wait_o  out  WAITW  largest wait_cnt value seen since reset or clear.
- starve_o  out  REQCNT  sticky starvation flags (optional feature).

Behaviour:
- Reset: when rst_n_i is low at a clk_i edge, all counters, wait_cnt, cl_gnt_o, drop_o, spurious_o, max_wait_o and starve_o go to 0. Consequently req_o = 0 and cl_full_o = 0.
  - Reset mid-operation discards all pending requests without producing grant pulses.
- Pending count cnt[i]:
  - Width is $clog2(MAXPEND+1).
  - Per cycle, the update is: +1 if cl_req_i[i] and not full; -1 if a valid grant hits i and cnt[i] != 0.
  - Request and grant in the same cycle leave cnt unchanged.
  - When full, a request with a simultaneous grant is accepted (net 0).
  - When full, a request without a grant is dropped and sets drop_o[i].
- Outputs:
  - req_o and cl_full_o are decoded from registered cnt, so they carry no combinational path from the inputs.
  - Latency: cl_req_i at edge N gives req_o high after edge N.
- Grant path:
  - A gnt_val_i with gnt_num_i = k at edge N makes cl_gnt_o = one-hot(k) for exactly the cycle after N, and cnt[k] decrements at the same edge.
  - cl_gnt_o is 0 in any cycle that follows no valid grant.
  - A grant to a client with cnt = 0, or an index >= REQCNT, is ignored: no pulse, no decrement, spurious_o set.
- Wait counters wait_cnt[i] (WAITW bits):
  - Cleared when cnt[i] = 0 or when a grant hits i.
  - Otherwise incremented each cycle, saturating at 2**WAITW-1.
- max_wait_o: registered; updated each cycle to the max of itself and all wait_cnt values.
- stat_clr_i:
  - Takes priority over the max_wait_o update and over flag setting in the same cycle: the result is 0 after that edge.
  - Does not affect cnt or wait_cnt.

Optional Feature:
- RR_REQ_AGENT_STARVE_CHECK_EN defined: starve_o[i] is set when wait_cnt[i] reaches STARVE_LIM, and stays set until stat_clr_i or reset.
- Not defined: starve_o is tied to 0 and no comparison logic is built. The port list is identical in both cases.

Test Plan:
- Reset: hold rst_n_i low for 2 cycles while driving cl_req_i = 4'b1111 -> after release, req_o = 0, cl_gnt_o = 0, max_wait_o = 0, all counters 0.
- Queueing and drop: pulse cl_req_i[2] for 4 consecutive cycles, no grants -> cnt[2] = 3, cl_full_o[2] = 1, drop_o[2] = 1, req_o = 4'b0100.
- Grant service: with cnt[1] = 2, issue gnt_val_i = 1, gnt_num_i = 1 on two consecutive cycles -> cl_gnt_o = 4'b0010 on the two following cycles, cnt[1] = 0, req_o[1] = 0 after the second grant.
- Simultaneous request and grant on a full client 0 -> cnt[0] stays 3, no drop_o, cl_gnt_o[0] pulses once.
- Spurious grant: grant index 3 while cnt[3] = 0 -> no pulse, spurious_o = 1; then stat_clr_i -> spurious_o = 0.
- Wait statistics with rr_top instantiated as REQCNT = 4, random cl_req_i for 10000 cycles -> max_wait_o <= 3*(REQCNT-1) = 9.
  - With RR_REQ_AGENT_STARVE_CHECK_EN and STARVE_LIM = 5, withholding grants from client 0 for 5 cycles sets starve_o[0].
